demux_sel_seq: RTL
==================

DEMUX_SEL_SEQ -- requirements
Module: demux_sel_seq

Interface
REQ-001 SHALL have parameter REV, default 0: channel order; 0 sends s = 0,1,2,3 and 1 sends s = 3,2,1,0.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-005 SHALL have port in_data, input, 4 bits: word; bit k is destined for channel k.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-007 SHALL have port hold, input, 1 bit: downstream stall request.
REQ-008 SHALL have port s_out, output, 2 bits: channel select driven to the 1:4 demux s input.
REQ-009 SHALL have port I_out, output, 1 bit: data bit driven to the demux I input.
REQ-010 SHALL have port out_valid, output, 1 bit: s_out/I_out pair is valid this cycle.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last channel of a word is sent.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 in_ready SHALL equal (state==IDLE) and not rst; it is combinational.
REQ-014 An accept SHALL occur when in_valid and in_ready are both 1 at a rising edge. On accept:
- in_data is latched into a 4-bit word register.
- The 2-bit index cnt is loaded with 0 (REV=0) or 3 (REV=1).
- state goes to SHIFT.
REQ-015 In IDLE, in_valid=0 SHALL leave state unchanged. Any in_valid while in_ready=0 SHALL be ignored, with no latch.
REQ-016 In SHIFT:
- s_out SHALL equal cnt.
- I_out SHALL equal word[cnt].
- out_valid SHALL equal not hold (combinational).
REQ-017 In SHIFT with hold=0, cnt SHALL step +1 (REV=0) or -1 (REV=1) each cycle. This is 2-bit modulo arithmetic, but the step SHALL never wrap within one word.
REQ-018 In SHIFT with hold=1, cnt, the word register and state SHALL freeze. s_out and I_out SHALL hold their values, and out_valid SHALL be 0.
REQ-019 When the final index (3 for REV=0, 0 for REV=1) is presented with hold=0, state SHALL go to DONE at the next edge.
REQ-020 In DONE:
- done=1 and out_valid=0.
- state SHALL return to IDLE at the next edge unconditionally; hold is ignored.
REQ-021 Outside SHIFT:
- out_valid=0.
- s_out and I_out SHALL hold their last SHIFT values (0 after reset).
- done=0, except in DONE.
REQ-022 Changes on in_data after an accept SHALL NOT affect the word in flight.
REQ-023 Latency with no hold (accept edge = edge t):
- four valid pairs SHALL appear in cycles t+1..t+4.
- done SHALL be 1 in cycle t+5.
- in_ready SHALL be 1 from cycle t+6.
- Maximum throughput is one word per 6 cycles.
REQ-024 Each cycle of hold=1 in SHIFT SHALL add exactly one cycle to REQ-023 timings.
REQ-025 Every word SHALL produce exactly 4 out_valid cycles, one per channel, each channel exactly once, in REQ-001 order.

Reset
REQ-026 rst=1 at an edge SHALL force:
- state=IDLE, cnt=0, word=0.
- s_out=0, I_out=0, out_valid=0, done=0.
- in_ready=0 while rst is high.
REQ-027 rst asserted mid-SHIFT or in DONE SHALL discard the word in flight with no done pulse. in_ready SHALL be 1 in the first cycle after rst falls.
REQ-028 rst SHALL take priority over accept, hold and all state transitions.

Verification
REQ-029 REV=0, in_data=4'b1011 accepted, hold=0 -> (s_out,I_out) = (0,1),(1,1),(2,0),(3,1) in cycles t+1..t+4; done=1 at t+5; in_ready=1 at t+6.
REQ-030 REV=1, in_data=4'b0110 -> (3,0),(2,1),(1,1),(0,0); then done pulse of 1 cycle.
REQ-031 REV=0, in_data=4'b1111 with hold=1 for 2 cycles while s_out=1 -> out_valid=0 and s_out=1 held for those cycles; done at t+7.
REQ-032 in_valid=1 with in_data toggling during SHIFT/DONE -> no extra accept; first word transmitted unchanged; second accept only in IDLE.
REQ-033 rst=1 at cycle t+2 of a word -> all outputs 0 next cycle; no done; a fresh word after rst falls is sent completely and correctly.

Source files
------------

// File: rtl/demux_sel_seq.sv
// demux_sel_seq: serialises a 4-bit word onto a 1:4 demux as (s_out,I_out) pairs; ports clk/rst, in_valid/in_data/in_ready upstream, hold/s_out/I_out/out_valid/done downstream
module demux_sel_seq #(
  parameter int REV = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       hold,
  output logic [1:0] s_out,
  output logic       I_out,
  output logic       out_valid,
  output logic       done
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] C_FIRST = (REV != 0) ? 2'd3 : 2'd0;
  localparam logic [1:0] C_LAST  = ~C_FIRST;
  state_t     r_state, w_next;
  logic [1:0] r_cnt, w_step;
  logic [3:0] r_word;
  logic       w_accept;
  assign w_accept = in_valid & in_ready;
  assign w_step   = (REV != 0) ? r_cnt - 2'd1 : r_cnt + 2'd1;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE)  ? (w_accept ? SHIFT : IDLE) :
             (r_state == SHIFT) ? ((!hold && r_cnt == C_LAST) ? DONE : SHIFT) :
                                  IDLE;
  end
  // cnt stops on the final index so s_out/I_out keep showing the last pair after the word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_word <= 4'd0;
    end else if (w_accept) begin
      r_cnt  <= C_FIRST;
      r_word <= in_data;
    end else if (r_state == SHIFT && !hold && r_cnt != C_LAST) begin
      r_cnt  <= w_step;
    end
  end
  always_comb begin
    in_ready  = (r_state == IDLE) && !rst;
    out_valid = (r_state == SHIFT) && !hold;
    done      = (r_state == DONE);
    s_out     = r_cnt;
    I_out     = r_word[r_cnt];
  end
endmodule
